// File: rtl/scratchpad_stream_dma_if.sv
// Stream handshake bundle (tdata/tvalid/tlast/tready) shared by the DMA input and output ports.
interface scratchpad_stream_dma_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/scratchpad_stream_dma.sv
// Stream <-> scratchpad DMA engine with a credit-limited read-return FIFO.
// Optional macro SCRATCHPAD_DMA_LAST_CHECK_EN ends a write early on input tlast and flags early_last.
module scratchpad_stream_dma #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_wr,
  input  logic                    start_rd,
  input  logic [15:0]             length,
  output logic                    busy,
  output logic                    done,
  output logic                    early_last,
  scratchpad_stream_dma_if.slave  s_axis,
  scratchpad_stream_dma_if.master m_axis,
  output logic                    dma_wr_en,
  output logic [DATA_WIDTH-1:0]   dma_wr_data,
  output logic [15:0]             dma_write_pointer,
  output logic                    dma_rd_en,
  output logic [15:0]             dma_read_pointer,
  input  logic [DATA_WIDTH-1:0]   dma_rd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  if (ADDR_WIDTH > 16 || FIFO_DEPTH < RD_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("scratchpad_stream_dma: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [15:0]           counter, len_q, len_m1, out_cnt, wr_ptr_q, rd_ptr_q;
  logic [RD_LATENCY-1:0] pipe;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]           fifo_wp, fifo_rp, occupancy;
  logic [PW+1:0]         inflight, credit_sum;
  logic                  start_acc, wr_beat, issue, push, pop, fifo_empty, last_word, early_beat;

  assign len_m1     = len_q - 16'd1;
  assign last_word  = (counter == len_m1);
  assign start_acc  = (state == IDLE) && (start_wr || start_rd);
  assign wr_beat    = (state == WRITE) && s_axis.tvalid;
  assign occupancy  = fifo_wp - fifo_rp;
  assign fifo_empty = (occupancy == '0);
  assign push       = pipe[RD_LATENCY-1];
  assign pop        = m_axis.tvalid && m_axis.tready;

  // Every issued read reserves a FIFO slot until it is popped, so returns can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {{(PW+1){1'b0}}, pipe[i]};
    end
    credit_sum = inflight + {1'b0, occupancy};
  end

  assign issue = (state == READ) && (credit_sum < DEPTH_W);

`ifdef SCRATCHPAD_DMA_LAST_CHECK_EN
  logic early_q;

  assign early_beat = s_axis.tlast && !last_word;
  assign early_last = early_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q <= 1'b0;
    end else if (start_acc) begin
      early_q <= 1'b0;
    end else if (wr_beat && early_beat) begin
      early_q <= 1'b1;
    end
  end
`else
  assign early_beat = 1'b0;
  assign early_last = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_wr) begin
          state_nxt = (length == 16'd0) ? DONE : WRITE;
        end else if (start_rd) begin
          state_nxt = (length == 16'd0) ? DONE : READ;
        end
      end
      WRITE:   if (wr_beat && (last_word || early_beat)) state_nxt = DONE;
      READ:    if (issue && last_word) state_nxt = DRAIN;
      DRAIN:   if ((pipe == '0) && fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      len_q    <= '0;
      out_cnt  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pipe     <= '0;
      fifo_wp  <= '0;
      fifo_rp  <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        len_q   <= length;
        counter <= '0;
        out_cnt <= '0;
      end else if (wr_beat || issue) begin
        counter <= counter + 16'd1;
      end
      if (wr_beat) wr_ptr_q <= counter;
      if (issue)   rd_ptr_q <= counter;
      pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (pop) begin
        fifo_rp <= fifo_rp + 1'b1;
        out_cnt <= out_cnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: head data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp[PW-1:0]] <= dma_rd_data;
  end

  assign busy              = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done              = (state == DONE);
  assign s_axis.tready     = (state == WRITE);
  assign dma_wr_en         = wr_beat;
  assign dma_wr_data       = wr_beat ? s_axis.tdata : '0;
  assign dma_write_pointer = wr_beat ? counter : wr_ptr_q;
  assign dma_rd_en         = issue;
  assign dma_read_pointer  = issue ? counter : rd_ptr_q;
  assign m_axis.tvalid     = !fifo_empty;
  assign m_axis.tdata      = m_axis.tvalid ? fifo_mem[fifo_rp[PW-1:0]] : '0;
  assign m_axis.tlast      = m_axis.tvalid && (out_cnt == len_m1);

endmodule

// File: tb/tb_scratchpad_stream_dma.sv
// Directed self-checking bench for scratchpad_stream_dma with a fixed-latency scratchpad model.
module tb_scratchpad_stream_dma;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_wr = 1'b0;
  logic          start_rd = 1'b0;
  logic [15:0]   length = '0;
  logic          busy, done, early_last;
  logic          dma_wr_en, dma_rd_en;
  logic [DW-1:0] dma_wr_data, dma_rd_data;
  logic [15:0]   dma_write_pointer, dma_read_pointer;

  scratchpad_stream_dma_if #(.DATA_WIDTH(DW)) s_if ();
  scratchpad_stream_dma_if #(.DATA_WIDTH(DW)) m_if ();

  always #5 clk = ~clk;

  scratchpad_stream_dma #(
    .ADDR_WIDTH(13), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd), .length(length),
    .busy(busy), .done(done), .early_last(early_last),
    .s_axis(s_if), .m_axis(m_if),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_write_pointer(dma_write_pointer),
    .dma_rd_en(dma_rd_en), .dma_read_pointer(dma_read_pointer), .dma_rd_data(dma_rd_data)
  );

  // Scratchpad model: data appears two cycles after the read strobe.
  logic [31:0] mem [0:255];
  logic [15:0] st0 = '0, st1 = '0;
  always @(posedge clk) begin
    st0 <= dma_read_pointer;
    st1 <= st0;
  end
  assign dma_rd_data = mem[st1[7:0]];

  int checks = 0, errors = 0;
  int cyc = 0, wr_n = 0, iss_n = 0, acc_n = 0, done_n = 0, busy_n = 0;
  int stab_err = 0, max_out = 0, last_wr_cyc = 0, done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] wr_ptr_log [0:63];
  logic [31:0] wr_dat_log [0:63];
  logic [31:0] rd_ptr_log [0:63];
  logic [31:0] out_dat_log [0:63];
  logic        out_last_log [0:63];
  int          beat_cyc_log [0:63];

  // Observe every handshake on the sampling edge and keep running logs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dma_wr_en) begin
      if (wr_n < 64) begin
        wr_ptr_log[wr_n] <= 32'(dma_write_pointer);
        wr_dat_log[wr_n] <= dma_wr_data;
      end
      wr_n <= wr_n + 1;
      last_wr_cyc <= cyc;
    end
    if (dma_rd_en) begin
      if (iss_n < 64) rd_ptr_log[iss_n] <= 32'(dma_read_pointer);
      iss_n <= iss_n + 1;
    end
    if (m_if.tvalid && m_if.tready) begin
      if (acc_n < 64) begin
        out_dat_log[acc_n]  <= m_if.tdata;
        out_last_log[acc_n] <= m_if.tlast;
        beat_cyc_log[acc_n] <= cyc;
      end
      acc_n <= acc_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_n <= busy_n + 1;
    if ((iss_n + int'(dma_rd_en)) - (acc_n + int'(m_if.tvalid && m_if.tready)) > max_out)
      max_out <= (iss_n + int'(dma_rd_en)) - (acc_n + int'(m_if.tvalid && m_if.tready));
    if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_data)) stab_err <= stab_err + 1;
    prev_stall <= m_if.tvalid && !m_if.tready;
    prev_data  <= m_if.tdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_write(input logic [15:0] len, input int tlast_at, input int budget);
    int base, d0, n;
    base = wr_n;
    d0 = done_n;
    n = 0;
    length = len;
    start_wr = 1'b1;
    tick();
    start_wr = 1'b0;
    s_if.tvalid = 1'b1;
    while (done_n == d0 && n < budget) begin
      s_if.tdata = 32'hA000_0000 + 32'(wr_n - base);
      s_if.tlast = ((wr_n - base) == tlast_at);
      tick();
      n++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    check_output("wr_done_seen", 32'(done_n != d0), 32'd1);
  endtask

  task automatic run_read(input logic [15:0] len, input bit toggle, input int budget);
    int d0, n;
    d0 = done_n;
    n = 0;
    m_if.tready = 1'b1;
    length = len;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    while (done_n == d0 && n < budget) begin
      if (toggle) m_if.tready = ~m_if.tready;
      tick();
      n++;
    end
    m_if.tready = 1'b1;
    check_output("rd_done_seen", 32'(done_n != d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wb, ib, ab, d0, bb, exp_n;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

    // Reset values while rst_n is held low.
    repeat (3) tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_s_tready", 32'(s_if.tready), 32'd0);
    check_output("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_output("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check_output("rst_wr_en", 32'(dma_wr_en), 32'd0);
    check_output("rst_rd_en", 32'(dma_rd_en), 32'd0);
    check_output("rst_wr_ptr", 32'(dma_write_pointer), 32'd0);
    check_output("rst_rd_ptr", 32'(dma_read_pointer), 32'd0);
    check_output("rst_wr_data", dma_wr_data, 32'd0);
    check_output("rst_m_tdata", m_if.tdata, 32'd0);
    check_output("rst_early_last", 32'(early_last), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write of four words with tvalid held high.
    wb = wr_n;
    d0 = done_n;
    run_write(16'd4, 99, 40);
    check_output("w4_count", 32'(wr_n - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_output("w4_ptr", wr_ptr_log[wb+i], 32'(i));
      check_output("w4_data", wr_dat_log[wb+i], 32'hA000_0000 + 32'(i));
    end
    check_output("w4_done_pulses", 32'(done_n - d0), 32'd1);
    check_output("w4_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
    check_output("w4_busy_after", 32'(busy), 32'd0);
    check_output("w4_ptr_held", 32'(dma_write_pointer), 32'd3);
    check_output("w4_s_tready_idle", 32'(s_if.tready), 32'd0);

    // Read of eight words at full throughput.
    ib = iss_n;
    ab = acc_n;
    d0 = done_n;
    run_read(16'd8, 1'b0, 60);
    check_output("r8_issue_count", 32'(iss_n - ib), 32'd8);
    check_output("r8_beat_count", 32'(acc_n - ab), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_output("r8_ptr", rd_ptr_log[ib+i], 32'(i));
      check_output("r8_data", out_dat_log[ab+i], 32'hC0DE_0000 + 32'(i));
      check_output("r8_last", 32'(out_last_log[ab+i]), 32'(i == 7));
    end
    check_output("r8_back_to_back", 32'(beat_cyc_log[ab+7] - beat_cyc_log[ab]), 32'd7);
    check_output("r8_done_pulses", 32'(done_n - d0), 32'd1);
    check_output("r8_rd_ptr_held", 32'(dma_read_pointer), 32'd7);

    // Read of sixteen words with tready toggling.
    for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 + 32'(i * 3);
    ab = acc_n;
    d0 = done_n;
    run_read(16'd16, 1'b1, 200);
    check_output("r16_beat_count", 32'(acc_n - ab), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_output("r16_data", out_dat_log[ab+i], 32'h5A00_0000 + 32'(i * 3));
      check_output("r16_last", 32'(out_last_log[ab+i]), 32'(i == 15));
    end
    check_output("r16_stable_when_stalled", 32'(stab_err), 32'd0);
    check_output("r16_outstanding_le_4", 32'(max_out <= 4), 32'd1);
    check_output("r16_done_pulses", 32'(done_n - d0), 32'd1);

    // Simultaneous starts with zero length.
    wb = wr_n;
    ib = iss_n;
    d0 = done_n;
    bb = busy_n;
    length = 16'd0;
    start_wr = 1'b1;
    start_rd = 1'b1;
    tick();
    start_wr = 1'b0;
    start_rd = 1'b0;
    check_output("z_done_now", 32'(done), 32'd1);
    check_output("z_busy_now", 32'(busy), 32'd0);
    tick();
    check_output("z_done_clear", 32'(done), 32'd0);
    repeat (5) tick();
    check_output("z_no_writes", 32'(wr_n - wb), 32'd0);
    check_output("z_no_reads", 32'(iss_n - ib), 32'd0);
    check_output("z_done_pulses", 32'(done_n - d0), 32'd1);
    check_output("z_never_busy", 32'(busy_n - bb), 32'd0);

    // Write of ten words with tlast on the third beat.
    wb = wr_n;
`ifdef SCRATCHPAD_DMA_LAST_CHECK_EN
    exp_n = 3;
`else
    exp_n = 10;
`endif
    run_write(16'd10, 2, 60);
    check_output("tl_count", 32'(wr_n - wb), 32'(exp_n));
    check_output("tl_early_last", 32'(early_last), 32'(exp_n == 3));
    for (int i = 0; i < 3; i++) begin
      check_output("tl_data", wr_dat_log[wb+i], 32'hA000_0000 + 32'(i));
    end
    wb = wr_n;
    run_write(16'd1, 99, 20);
    check_output("tl_clear_early", 32'(early_last), 32'd0);
    check_output("tl_single_count", 32'(wr_n - wb), 32'd1);
    check_output("tl_single_ptr", wr_ptr_log[wb], 32'd0);

    // Reset with two reads in flight.
    m_if.tready = 1'b0;
    ib = iss_n;
    length = 16'd16;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    tick();
    tick();
    check_output("mr_two_issued", 32'(iss_n - ib), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("mr_busy", 32'(busy), 32'd0);
    check_output("mr_done", 32'(done), 32'd0);
    check_output("mr_rd_en", 32'(dma_rd_en), 32'd0);
    check_output("mr_wr_en", 32'(dma_wr_en), 32'd0);
    check_output("mr_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_output("mr_m_tlast", 32'(m_if.tlast), 32'd0);
    check_output("mr_s_tready", 32'(s_if.tready), 32'd0);
    check_output("mr_rd_ptr", 32'(dma_read_pointer), 32'd0);
    check_output("mr_wr_ptr", 32'(dma_write_pointer), 32'd0);
    check_output("mr_wr_data", dma_wr_data, 32'd0);
    check_output("mr_m_tdata", m_if.tdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ab = acc_n;
    d0 = done_n;
    m_if.tready = 1'b1;
    repeat (10) tick();
    check_output("mr_no_beats_after", 32'(acc_n - ab), 32'd0);
    check_output("mr_no_done_after", 32'(done_n - d0), 32'd0);
    check_output("mr_idle_busy", 32'(busy), 32'd0);
    check_output("mr_idle_tvalid", 32'(m_if.tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
